// File: rtl/pipe_fwd_pkg.sv
// Shared select codes, shadow-stage record and helpers for the forwarding/hazard controller.
package pipe_fwd_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] SEL_DE = 2'b00;
   localparam logic [1:0] SEL_MW = 2'b01;
   localparam logic [1:0] SEL_EM = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } shadow_t;

   // The youngest producer (E) outranks the older one (M).
   function automatic logic [1:0] pick_sel(input logic hit_e, input logic hit_m);
      if (hit_e)      return SEL_EM;
      else if (hit_m) return SEL_MW;
      else            return SEL_DE;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Match predicate: one source register against one shadow stage; x0 never matches.
module fwd_match #(
   parameter int REG_AW = 5
) (
   input  logic              valid,
   input  logic              regwrite,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] src,
   output logic              hit
);

   assign hit = valid & regwrite & (rd != '0) & (rd == src);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects and load-use stall/bubble for the 5-stage pipeline.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_ctrl
   import pipe_fwd_pkg::*;
#(
   parameter int REG_AW = pipe_fwd_pkg::REG_AW
`ifdef FWD_PERF_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic              memread_d,
   input  logic              flush_e,
   output logic [1:0]        s1,
   output logic [1:0]        s2,
   output logic              stall_fd,
   output logic              bubble_e
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  fwd_cnt
`endif
);

   shadow_t           sh_e;
   // M keeps only what its match needs: memread matters only in E, and
   // W producers reach the consumer through the write-first register file.
   logic              m_valid;
   logic              m_regwrite;
   logic [REG_AW-1:0] m_rd;

   logic hit_e1, hit_e2, hit_m1, hit_m2;
   logic load_use, kill;
   logic [1:0] s1_n, s2_n;

   fwd_match #(.REG_AW(REG_AW)) u_e1 (
      .valid(sh_e.valid), .regwrite(sh_e.regwrite), .rd(sh_e.rd), .src(rs1_d), .hit(hit_e1));
   fwd_match #(.REG_AW(REG_AW)) u_e2 (
      .valid(sh_e.valid), .regwrite(sh_e.regwrite), .rd(sh_e.rd), .src(rs2_d), .hit(hit_e2));
   fwd_match #(.REG_AW(REG_AW)) u_m1 (
      .valid(m_valid), .regwrite(m_regwrite), .rd(m_rd), .src(rs1_d), .hit(hit_m1));
   fwd_match #(.REG_AW(REG_AW)) u_m2 (
      .valid(m_valid), .regwrite(m_regwrite), .rd(m_rd), .src(rs2_d), .hit(hit_m2));

   assign load_use = valid_d & sh_e.valid & sh_e.memread & (hit_e1 | hit_e2);
   // A taken branch kills the consumer anyway, so it overrides the stall.
   assign stall_fd = load_use & ~flush_e;
   assign bubble_e = stall_fd;

   assign kill = flush_e | bubble_e | ~valid_d;
   assign s1_n = kill ? SEL_DE : pick_sel(hit_e1, hit_m1);
   assign s2_n = kill ? SEL_DE : pick_sel(hit_e2, hit_m2);

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_e       <= '0;
         m_valid    <= 1'b0;
         m_regwrite <= 1'b0;
         m_rd       <= '0;
         s1         <= SEL_DE;
         s2         <= SEL_DE;
      end else begin
         if (kill) sh_e <= '0;
         else      sh_e <= '{valid: 1'b1, rd: rd_d, regwrite: regwrite_d, memread: memread_d};
         m_valid    <= sh_e.valid;
         m_regwrite <= sh_e.regwrite;
         m_rd       <= sh_e.rd;
         s1         <= s1_n;
         s2         <= s2_n;
      end
   end

`ifdef FWD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall_fd && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (((s1_n != SEL_DE) || (s2_n != SEL_DE)) && fwd_cnt != '1)
            fwd_cnt <= fwd_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vectors, literal pins and a reference model.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset, valid_d, regwrite_d, memread_d, flush_e;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic [1:0] s1, s2;
   logic       stall_fd, bubble_e;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   fwd_hazard_ctrl dut (
      .clk(clk), .reset(reset), .valid_d(valid_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .regwrite_d(regwrite_d), .memread_d(memread_d), .flush_e(flush_e),
      .s1(s1), .s2(s2), .stall_fd(stall_fd), .bubble_e(bubble_e)
`ifdef FWD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: the instruction now in E and the one now in M, plus the selects
   // the consumer that just entered E must see.
   typedef struct { bit v; int rd; bit rw; bit ld; } pst_t;
   pst_t       me, mm;
   logic [1:0] ms1, ms2;
   bit         mdl_ok = 1'b0;
   bit         m_stall = 1'b0;
   bit         st, kl;

   function automatic bit hits(input int src, input pst_t p);
      return p.v && p.rw && (p.rd != 0) && (p.rd == src);
   endfunction

   function automatic logic [1:0] want(input int src);
      if (hits(src, me))      return 2'b10;
      else if (hits(src, mm)) return 2'b01;
      else                    return 2'b00;
   endfunction

   function automatic bit want_stall();
      return valid_d && me.ld && (hits(int'(rs1_d), me) || hits(int'(rs2_d), me)) && !flush_e;
   endfunction

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("s1", {30'd0, s1}, {30'd0, ms1});
         chk("s2", {30'd0, s2}, {30'd0, ms2});
         chk("stall_fd", {31'd0, stall_fd}, {31'd0, want_stall()});
         chk("bubble_e", {31'd0, bubble_e}, {31'd0, want_stall()});
      end
      if (reset) begin
         me = '{default: 0};
         mm = '{default: 0};
         ms1 = 2'b00;
         ms2 = 2'b00;
         m_stall = 1'b0;
         mdl_ok = 1'b1;
      end else begin
         st  = want_stall();
         kl  = st || flush_e || !valid_d;
         ms1 = kl ? 2'b00 : want(int'(rs1_d));
         ms2 = kl ? 2'b00 : want(int'(rs2_d));
         mm  = me;
         if (kl) me = '{default: 0};
         else    me = '{v: 1'b1, rd: int'(rd_d), rw: regwrite_d, ld: memread_d};
         m_stall = st;
      end
   end

   task automatic setd(input int a, input int b, input int d, input bit rw, input bit ld);
      valid_d = 1'b1; rs1_d = 5'(a); rs2_d = 5'(b); rd_d = 5'(d);
      regwrite_d = rw; memread_d = ld; flush_e = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; valid_d = 1'b0; rs1_d = '0; rs2_d = '0; rd_d = '0;
      regwrite_d = 1'b0; memread_d = 1'b0; flush_e = 1'b0;
      tick(); tick();
      chk("rst_s1", {30'd0, s1}, 32'd0);
      chk("rst_s2", {30'd0, s2}, 32'd0);
      chk("rst_stall", {31'd0, stall_fd}, 32'd0);
`ifdef FWD_PERF_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_fwd_cnt", fwd_cnt, 32'd0);
`endif
      reset = 1'b0;

      // adjacent dependency
      setd(1, 2, 5, 1, 0); tick();
      setd(5, 7, 6, 1, 0); #1 chk("adj_stall", {31'd0, stall_fd}, 32'd0); tick();
      chk("adj_s1", {30'd0, s1}, 32'h2);
      chk("adj_s2", {30'd0, s2}, 32'h0);

      // distance-2 dependency
      setd(1, 2, 5, 1, 0); tick();
      setd(0, 0, 0, 1, 0); tick();
      setd(9, 5, 8, 1, 0); tick();
      chk("d2_s1", {30'd0, s1}, 32'h0);
      chk("d2_s2", {30'd0, s2}, 32'h1);

      // double producer, youngest wins
      setd(1, 2, 5, 1, 0); tick();
      setd(5, 0, 5, 1, 0); tick();
      setd(5, 3, 10, 1, 0); tick();
      chk("dbl_s1", {30'd0, s1}, 32'h2);
      chk("dbl_s2", {30'd0, s2}, 32'h0);

      // load-use: one stall, then M/W forward on both operands
      setd(1, 0, 5, 1, 1); tick();
      setd(5, 5, 6, 1, 0); #1
      chk("lu_stall", {31'd0, stall_fd}, 32'd1);
      chk("lu_bubble", {31'd0, bubble_e}, 32'd1);
      tick();
      chk("lu_bub_s1", {30'd0, s1}, 32'h0);
      chk("lu_stall2", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("lu_s1", {30'd0, s1}, 32'h1);
      chk("lu_s2", {30'd0, s2}, 32'h1);
`ifdef FWD_PERF_CNT_EN
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      chk("lu_fwd_cnt", fwd_cnt, 32'd5);
`endif

      // x0 producer and regwrite gating
      setd(1, 0, 0, 1, 0); tick();
      setd(0, 0, 4, 1, 0); tick();
      chk("x0_s1", {30'd0, s1}, 32'h0);
      chk("x0_s2", {30'd0, s2}, 32'h0);
      setd(3, 2, 2, 0, 0); tick();
      setd(2, 3, 3, 0, 0); tick();
      chk("st_s1", {30'd0, s1}, 32'h0);
      chk("st_s2", {30'd0, s2}, 32'h0);
      setd(1, 0, 0, 1, 1); tick();
      setd(0, 0, 4, 1, 0); #1 chk("x0_ld_stall", {31'd0, stall_fd}, 32'd0); tick();
      chk("x0_ld_s1", {30'd0, s1}, 32'h0);

      // load-use together with flush
      setd(1, 0, 5, 1, 1); tick();
      setd(5, 5, 6, 1, 0); flush_e = 1'b1; #1
      chk("fl_stall", {31'd0, stall_fd}, 32'd0);
      chk("fl_bubble", {31'd0, bubble_e}, 32'd0);
      tick();
      chk("fl_s1", {30'd0, s1}, 32'h0);
      chk("fl_s2", {30'd0, s2}, 32'h0);

      // reset mid-stream drops the producer
      setd(1, 2, 5, 1, 0); reset = 1'b1; tick();
      chk("mr_s1", {30'd0, s1}, 32'h0);
      chk("mr_stall", {31'd0, stall_fd}, 32'd0);
      reset = 1'b0;
      setd(5, 5, 7, 1, 0); #1 chk("mr_stall2", {31'd0, stall_fd}, 32'd0); tick();
      chk("mr_s1b", {30'd0, s1}, 32'h0);
      chk("mr_s2b", {30'd0, s2}, 32'h0);

      // randomized traffic against the model, D held while stalled
      for (int i = 0; i < 400; i++) begin
         if (!m_stall) begin
            valid_d    = ($urandom_range(0, 7) != 0);
            rs1_d      = 5'($urandom_range(0, 6));
            rs2_d      = 5'($urandom_range(0, 6));
            rd_d       = 5'($urandom_range(0, 6));
            regwrite_d = ($urandom_range(0, 4) != 0);
            memread_d  = ($urandom_range(0, 2) == 0);
         end
         flush_e = ($urandom_range(0, 15) == 0);
         reset   = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset = 1'b0; valid_d = 1'b0; flush_e = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
